// File: rtl/mix_columns_if.sv
// mix_columns_if: byte-stream bus for mix_columns_serial
//  din/en_din/final_rnd (and inv when MIXCOL_INV_EN is defined) flow master->slave;
//  dout/en_dout/busy/ovf/blk flow slave->master.
interface mix_columns_if #(
   parameter int CNT_W = 8
);
   logic [7:0]       din;
   logic             en_din;
   logic             final_rnd;
`ifdef MIXCOL_INV_EN
   logic             inv;
`endif
   logic [7:0]       dout;
   logic             en_dout;
   logic             busy;
   logic             ovf;
   logic [CNT_W-1:0] blk;
`ifdef MIXCOL_INV_EN
   modport master (output din, en_din, final_rnd, inv, input dout, en_dout, busy, ovf, blk);
   modport slave  (input din, en_din, final_rnd, inv, output dout, en_dout, busy, ovf, blk);
`else
   modport master (output din, en_din, final_rnd, input dout, en_dout, busy, ovf, blk);
   modport slave  (input din, en_din, final_rnd, output dout, en_dout, busy, ovf, blk);
`endif
endinterface

// File: rtl/mix_columns_serial.sv
// mix_columns_serial: byte-serial AES MixColumns, buffers a row-major 16-byte state and streams it back out
//  clk, rst_n (async active-low); bus.slave: din/en_din/final_rnd in, dout/en_dout/busy/ovf/blk out.
//  MIXCOL_INV_EN adds bus.inv, sampled with byte 0, selecting InvMixColumns.
module mix_columns_serial #(
   parameter int NB_BYTES = 16,
   parameter int CNT_W    = 8
) (
   input logic          clk,
   input logic          rst_n,
   mix_columns_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUT} state_t;
   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       mem [NB_BYTES];
   logic [7:0]       a [4];
   logic [7:0]       r [4];
   logic [3:0]       coef [4];
   logic             byp;
`ifdef MIXCOL_INV_EN
   logic             inv_q;
`endif

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // constant multiply as a sum of xt powers selected by the coefficient bits
   function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
      logic [7:0] x1, x2, x3;
      x1 = xt(b);
      x2 = xt(x1);
      x3 = xt(x2);
      return (c[0] ? b : 8'h00) ^ (c[1] ? x1 : 8'h00) ^ (c[2] ? x2 : 8'h00) ^ (c[3] ? x3 : 8'h00);
   endfunction

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = bus.en_din ? LOAD : IDLE;
         LOAD:    state_nx = (bus.en_din && cnt == CNT_W'(NB_BYTES - 1)) ? COMPUTE : LOAD;
         COMPUTE: state_nx = (cnt == CNT_W'(3)) ? OUT : COMPUTE;
         default: state_nx = (cnt == CNT_W'(NB_BYTES)) ? IDLE : OUT;
      endcase
   end

   // row r of the matrix uses coefficient coef[(j-r) mod 4] for column byte a[j]
   always_comb begin
`ifdef MIXCOL_INV_EN
      coef = inv_q ? '{4'he, 4'hb, 4'hd, 4'h9} : '{4'h2, 4'h3, 4'h1, 4'h1};
`else
      coef = '{4'h2, 4'h3, 4'h1, 4'h1};
`endif
      a[0] = mem[{2'd0, cnt[1:0]}];
      a[1] = mem[{2'd1, cnt[1:0]}];
      a[2] = mem[{2'd2, cnt[1:0]}];
      a[3] = mem[{2'd3, cnt[1:0]}];
      for (int i = 0; i < 4; i++) begin
         r[i] = 8'h00;
         for (int j = 0; j < 4; j++) r[i] = r[i] ^ gm(a[j], coef[2'(j - i)]);
      end
   end

   // IDLE always has cnt=0, so byte 0 and later bytes share the same write path
   always_ff @(posedge clk)
      if (bus.en_din && (state == IDLE || state == LOAD)) mem[cnt[3:0]] <= bus.din;
      else if (state == COMPUTE && !byp) begin
         mem[{2'd0, cnt[1:0]}] <= r[0];
         mem[{2'd1, cnt[1:0]}] <= r[1];
         mem[{2'd2, cnt[1:0]}] <= r[2];
         mem[{2'd3, cnt[1:0]}] <= r[3];
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt         <= '0;
         byp         <= 1'b0;
`ifdef MIXCOL_INV_EN
         inv_q       <= 1'b0;
`endif
         bus.dout    <= 8'h00;
         bus.en_dout <= 1'b0;
         bus.ovf     <= 1'b0;
         bus.blk     <= '0;
      end else begin
         if (bus.en_din && (state == COMPUTE || state == OUT)) bus.ovf <= 1'b1;
         case (state)
            IDLE: if (bus.en_din) begin
               cnt   <= CNT_W'(1);
               byp   <= bus.final_rnd;
`ifdef MIXCOL_INV_EN
               inv_q <= bus.inv;
`endif
            end
            LOAD:    if (bus.en_din) cnt <= (cnt == CNT_W'(NB_BYTES - 1)) ? '0 : cnt + 1'b1;
            COMPUTE: cnt <= (cnt == CNT_W'(3)) ? '0 : cnt + 1'b1;
            default: if (cnt == CNT_W'(NB_BYTES)) begin
               cnt         <= '0;
               bus.en_dout <= 1'b0;
               bus.blk     <= bus.blk + 1'b1;
            end else begin
               cnt         <= cnt + 1'b1;
               bus.dout    <= mem[cnt[3:0]];
               bus.en_dout <= 1'b1;
            end
         endcase
      end

   assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_mix_columns_serial.sv
// tb_mix_columns_serial: scoreboard bench for mix_columns_serial with a GF(2^8) matrix reference model
module tb_mix_columns_serial;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   ncmp = 0;
   int   nerr = 0;
   logic [7:0] exp_q[$];
   int         e_q[$];
   logic [7:0] blk_exp = 8'h00;
   int         run = 0;
   logic [7:0] last = 8'h00;

   logic [7:0] fips_in[16]  = '{8'hdb, 8'hf2, 8'h01, 8'hd4, 8'h13, 8'h0a, 8'h01, 8'hbf,
                                8'h53, 8'h22, 8'h01, 8'h5d, 8'h45, 8'h5c, 8'h01, 8'h30};
   logic [7:0] fips_out[16] = '{8'h8e, 8'h9f, 8'h01, 8'h04, 8'h4d, 8'hdc, 8'h01, 8'h66,
                                8'ha1, 8'h58, 8'h01, 8'h81, 8'hbc, 8'h9d, 8'h01, 8'he5};

   mix_columns_if bus();
   mix_columns_serial dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      ncmp++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (y[k]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic void model(input logic [7:0] d[16], input logic fr, input logic iv,
                                 output logic [7:0] o[16]);
      logic [7:0] fm[4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
                               '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
      logic [7:0] im[4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                               '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
      for (int row = 0; row < 4; row++)
         for (int col = 0; col < 4; col++) begin
            o[4*row+col] = 8'h00;
            for (int k = 0; k < 4; k++)
               o[4*row+col] ^= gmul(iv ? im[row][k] : fm[row][k], d[4*k+col]);
            if (fr) o[4*row+col] = d[4*row+col];
         end
   endfunction

   task automatic put_byte(input logic [7:0] d, input logic fr, input logic iv);
      @(negedge clk);
      bus.din       = d;
      bus.en_din    = 1'b1;
      bus.final_rnd = fr;
`ifdef MIXCOL_INV_EN
      bus.inv       = iv;
`else
      if (iv) $display("inverse requested without MIXCOL_INV_EN");
`endif
      @(posedge clk);
      #1 bus.en_din = 1'b0;
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 100 && bus.busy; t++) @(negedge clk);
      chk("busy_drop", bus.busy, 1'b0);
   endtask

   task automatic send_block(input logic [7:0] d[16], input logic fr, input logic iv,
                             input int maxgap, input bit pulse, input logic [7:0] ex[16]);
      for (int i = 0; i < 16; i++) exp_q.push_back(ex[i]);
      for (int i = 0; i < 16; i++) begin
         if (i > 0 && maxgap > 0) repeat ($urandom_range(maxgap, 1)) @(posedge clk);
         put_byte(d[i], fr, iv);
      end
      e_q.push_back(cyc);
      if (pulse) begin
         repeat (21) begin
            @(negedge clk);
            bus.en_din = 1'($urandom);
            bus.din    = 8'($urandom);
         end
         @(negedge clk);
         bus.en_din = 1'b0;
      end
      wait_idle();
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         run     = 0;
         blk_exp = 8'h00;
      end else if (bus.en_dout) begin
         if (run == 0) chk("latency", cyc, (e_q.size() > 0) ? e_q.pop_front() + 5 : -1);
         if (exp_q.size() == 0) chk("unexpected_byte", bus.dout, 8'hxx);
         else chk($sformatf("dout[%0d]", run), bus.dout, exp_q.pop_front());
         last = bus.dout;
         run++;
      end else if (run != 0) begin
         blk_exp++;
         chk("en_dout_len", run, 16);
         chk("blk", bus.blk, blk_exp);
         chk("dout_hold", bus.dout, last);
         chk("busy_end", bus.busy, 1'b0);
         run = 0;
      end
   end

   initial begin
      logic [7:0] d[16];
      logic [7:0] o[16];
      logic fr, iv;
      bus.din = 8'h00;
      bus.en_din = 1'b0;
      bus.final_rnd = 1'b0;
`ifdef MIXCOL_INV_EN
      bus.inv = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_dout", bus.dout, 8'h00);
      chk("rst_en_dout", bus.en_dout, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_ovf", bus.ovf, 1'b0);
      chk("rst_blk", bus.blk, 8'h00);
      rst_n = 1'b1;
      model(fips_in, 1'b0, 1'b0, o);
      foreach (o[i]) chk("model_fips", o[i], fips_out[i]);
      send_block(fips_in, 1'b0, 1'b0, 0, 1'b0, fips_out);
      send_block(fips_in, 1'b1, 1'b0, 0, 1'b0, fips_in);
      send_block(fips_in, 1'b0, 1'b0, 3, 1'b0, fips_out);
      chk("ovf_clear", bus.ovf, 1'b0);
      send_block(fips_in, 1'b0, 1'b0, 0, 1'b1, fips_out);
      chk("ovf_set", bus.ovf, 1'b1);
      send_block(fips_in, 1'b1, 1'b0, 2, 1'b0, fips_in);
      chk("ovf_sticky", bus.ovf, 1'b1);
      for (int i = 0; i < 7; i++) put_byte(8'($urandom), 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_dout", bus.dout, 8'h00);
      chk("arst_en_dout", bus.en_dout, 1'b0);
      chk("arst_busy", bus.busy, 1'b0);
      chk("arst_ovf", bus.ovf, 1'b0);
      chk("arst_blk", bus.blk, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      send_block(fips_in, 1'b0, 1'b0, 1, 1'b0, fips_out);
`ifdef MIXCOL_INV_EN
      send_block(fips_out, 1'b0, 1'b1, 0, 1'b0, fips_in);
`endif
      for (int b = 0; b < 260; b++) begin
         foreach (d[i]) d[i] = 8'($urandom);
         fr = ($urandom_range(3, 0) == 0);
`ifdef MIXCOL_INV_EN
         iv = 1'($urandom);
`else
         iv = 1'b0;
`endif
         model(d, fr, iv, o);
         send_block(d, fr, iv, (b % 4 == 0) ? 3 : 0, 1'b0, o);
      end
      repeat (3) @(negedge clk);
      chk("drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
